// File: rtl/issue_scheduler_pkg.sv
// Shared types and constants for the dual-issue scheduler: state encodings,
// register-address width, bubble counter width and the default redirect bubble.
package issue_scheduler_pkg;
   localparam int REG_ADDR_W       = 5;
   localparam int FLUSH_CYCLES_DEF = 1;
   localparam int BUBBLE_W         = 4;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef enum logic [1:0] {
      IS_RUN   = 2'd0,
      IS_SPLIT = 2'd1,
      IS_REDIR = 2'd2
   } is_state_t;

   // $0 is hardwired, so a write to it can never create a dependency.
   function automatic logic raw_hit(input reg_addr_t rd, input reg_addr_t rs,
                                    input reg_addr_t rt);
      return (rd != '0) && ((rd == rs) || (rd == rt));
   endfunction
endpackage

// File: rtl/issue_scheduler_if.sv
// Issue-stage bus between the fetch-queue/decode pair, the scheduler and the
// two execute lanes. master drives the instruction pair, slave is the scheduler.
interface issue_scheduler_if #(parameter int PAYLOAD_W = 64);
   import issue_scheduler_pkg::*;

   logic                 is_i_valid0;
   logic                 is_i_valid1;
   reg_addr_t            is_i_rs0;
   reg_addr_t            is_i_rt0;
   reg_addr_t            is_i_rd0;
   reg_addr_t            is_i_rs1;
   reg_addr_t            is_i_rt1;
   reg_addr_t            is_i_rd1;
   logic                 is_i_wr0;
   logic                 is_i_jump0;
   logic [PAYLOAD_W-1:0] is_i_payload0;
   logic [PAYLOAD_W-1:0] is_i_payload1;
   logic                 is_i_change_pc;
   logic                 is_o_ready;
   logic                 is_o_issue0;
   logic                 is_o_issue1;
   logic [PAYLOAD_W-1:0] is_o_payload0;
   logic [PAYLOAD_W-1:0] is_o_payload1;
   logic                 is_o_flush;
   logic [31:0]          is_o_dual_cnt;
   logic [31:0]          is_o_split_cnt;
   logic [31:0]          is_o_flush_cnt;

   modport master (
      output is_i_valid0, is_i_valid1, is_i_rs0, is_i_rt0, is_i_rd0,
             is_i_rs1, is_i_rt1, is_i_rd1, is_i_wr0, is_i_jump0,
             is_i_payload0, is_i_payload1, is_i_change_pc,
      input  is_o_ready, is_o_issue0, is_o_issue1, is_o_payload0, is_o_payload1,
             is_o_flush, is_o_dual_cnt, is_o_split_cnt, is_o_flush_cnt
   );

   modport slave (
      input  is_i_valid0, is_i_valid1, is_i_rs0, is_i_rt0, is_i_rd0,
             is_i_rs1, is_i_rt1, is_i_rd1, is_i_wr0, is_i_jump0,
             is_i_payload0, is_i_payload1, is_i_change_pc,
      output is_o_ready, is_o_issue0, is_o_issue1, is_o_payload0, is_o_payload1,
             is_o_flush, is_o_dual_cnt, is_o_split_cnt, is_o_flush_cnt
   );
endinterface

// File: rtl/issue_scheduler_hazard_check.sv
// issue_hazard_check: combinational pair-split decision (slot 0 jump or
// slot 1 reading slot 0's destination); also usable by forwarding logic.
module issue_hazard_check
   import issue_scheduler_pkg::*;
(
   input  logic      valid0,
   input  logic      valid1,
   input  logic      jump0,
   input  logic      wr0,
   input  reg_addr_t rd0,
   input  reg_addr_t rs1,
   input  reg_addr_t rt1,
   output logic      hazard
);
   // rt1 is compared even for instructions that do not read it (conservative).
   assign hazard = valid0 && valid1 && (jump0 || (wr0 && raw_hit(rd0, rs1, rt1)));
endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: issues a decoded pair together, or splits it on a hazard,
// and inserts a flush bubble on redirect. ISSUE_SCHED_STATS_EN builds the counters.
//
// state    | meaning
// IS_RUN   | accepting pairs from the fetch queue
// IS_SPLIT | slot 0 issued, held slot 1 issues next cycle
// IS_REDIR | redirect bubble, counting down before accepting again
module issue_scheduler
   import issue_scheduler_pkg::*;
#(
   parameter int PAYLOAD_W    = 64,
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
   input logic              is_i_clk,
   input logic              is_i_rst,
   issue_scheduler_if.slave bus
);
   localparam logic [BUBBLE_W-1:0] BUBBLE_LOAD = BUBBLE_W'(FLUSH_CYCLES);

   is_state_t            state;
   logic [BUBBLE_W-1:0]  bubble;
   logic [PAYLOAD_W-1:0] hold;
   logic                 issue0;
   logic                 issue1;
   logic                 flush;
   logic [PAYLOAD_W-1:0] payload0;
   logic [PAYLOAD_W-1:0] payload1;
   logic                 ready;
   logic                 accept;
   logic                 hazard;
   logic                 unused_fields;

   issue_hazard_check u_hazard (
      .valid0 (bus.is_i_valid0),
      .valid1 (bus.is_i_valid1),
      .jump0  (bus.is_i_jump0),
      .wr0    (bus.is_i_wr0),
      .rd0    (bus.is_i_rd0),
      .rs1    (bus.is_i_rs1),
      .rt1    (bus.is_i_rt1),
      .hazard (hazard)
   );

   // Slot 0 sources and slot 1 destination matter only to forwarding, not here.
   assign unused_fields = ^{bus.is_i_rs0, bus.is_i_rt0, bus.is_i_rd1};

   always_comb begin
      ready  = (state == IS_RUN) && !bus.is_i_change_pc;
      accept = ready && (bus.is_i_valid0 || bus.is_i_valid1);
   end

   always_ff @(posedge is_i_clk or posedge is_i_rst) begin
      if (is_i_rst) begin
         state    <= IS_RUN;
         bubble   <= '0;
         hold     <= '0;
         issue0   <= 1'b0;
         issue1   <= 1'b0;
         flush    <= 1'b0;
         payload0 <= '0;
         payload1 <= '0;
      end else if (bus.is_i_change_pc) begin
         // Redirect wins in every state; a held slot 1 is dropped here.
         issue0 <= 1'b0;
         issue1 <= 1'b0;
         hold   <= '0;
         flush  <= 1'b1;
         bubble <= BUBBLE_LOAD;
         state  <= IS_REDIR;
      end else begin
         flush <= 1'b0;
         case (state)
            IS_RUN: begin
               if (accept && hazard) begin
                  issue0   <= 1'b1;
                  issue1   <= 1'b0;
                  payload0 <= bus.is_i_payload0;
                  hold     <= bus.is_i_payload1;
                  state    <= IS_SPLIT;
               end else if (accept) begin
                  issue0   <= bus.is_i_valid0;
                  issue1   <= bus.is_i_valid1;
                  payload0 <= bus.is_i_payload0;
                  payload1 <= bus.is_i_payload1;
               end else begin
                  issue0 <= 1'b0;
                  issue1 <= 1'b0;
               end
            end
            IS_SPLIT: begin
               issue0   <= 1'b0;
               issue1   <= 1'b1;
               payload1 <= hold;
               state    <= IS_RUN;
            end
            IS_REDIR: begin
               issue0 <= 1'b0;
               issue1 <= 1'b0;
               bubble <= bubble - BUBBLE_W'(1);
               if (bubble <= BUBBLE_W'(1)) state <= IS_RUN;
            end
            default: begin
               issue0 <= 1'b0;
               issue1 <= 1'b0;
               state  <= IS_RUN;
            end
         endcase
      end
   end

   assign bus.is_o_ready    = ready;
   assign bus.is_o_issue0   = issue0;
   assign bus.is_o_issue1   = issue1;
   assign bus.is_o_payload0 = payload0;
   assign bus.is_o_payload1 = payload1;
   assign bus.is_o_flush    = flush;

`ifdef ISSUE_SCHED_STATS_EN
   logic [31:0] dual_cnt;
   logic [31:0] split_cnt;
   logic [31:0] flush_cnt;

   // Counted on the edge that loads the outputs, so they line up with issue/flush.
   always_ff @(posedge is_i_clk or posedge is_i_rst) begin
      if (is_i_rst) begin
         dual_cnt  <= '0;
         split_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (accept && !hazard && bus.is_i_valid0 && bus.is_i_valid1)
            dual_cnt <= dual_cnt + 32'd1;
         if (accept && hazard)
            split_cnt <= split_cnt + 32'd1;
         if (bus.is_i_change_pc)
            flush_cnt <= flush_cnt + 32'd1;
      end
   end

   assign bus.is_o_dual_cnt  = dual_cnt;
   assign bus.is_o_split_cnt = split_cnt;
   assign bus.is_o_flush_cnt = flush_cnt;
`else
   assign bus.is_o_dual_cnt  = 32'd0;
   assign bus.is_o_split_cnt = 32'd0;
   assign bus.is_o_flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed pairs plus a timestamp-based model checked
// every cycle; counter expectations follow ISSUE_SCHED_STATS_EN.
module tb_issue_scheduler;
   localparam int PW = 64;
   localparam int FC = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   issue_scheduler_if #(.PAYLOAD_W(PW)) bus();

   issue_scheduler #(.PAYLOAD_W(PW), .FLUSH_CYCLES(FC)) dut (
      .is_i_clk (clk),
      .is_i_rst (rst),
      .bus      (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: ready is blocked until cycle ready_from, or while slot 1 is owed.
   int          cyc = 0;
   int          ready_from = 0;
   bit          split_due = 1'b0;
   logic [PW-1:0] held = '0;
   logic          m_i0 = 1'b0, m_i1 = 1'b0, m_fl = 1'b0;
   logic [PW-1:0] m_p0 = '0, m_p1 = '0;
   logic [31:0]   m_dual = '0, m_split = '0, m_flush = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_hazard();
      logic dep;
      dep = bus.is_i_wr0 && (bus.is_i_rd0 != 5'd0) &&
            ((bus.is_i_rd0 == bus.is_i_rs1) || (bus.is_i_rd0 == bus.is_i_rt1));
      return bus.is_i_valid0 && bus.is_i_valid1 && (bus.is_i_jump0 || dep);
   endfunction

   function automatic logic model_ready();
      return (cyc >= ready_from) && !split_due && !bus.is_i_change_pc;
   endfunction

   task automatic model_reset();
      ready_from = cyc;
      split_due  = 1'b0;
      held       = '0;
      m_i0 = 1'b0; m_i1 = 1'b0; m_fl = 1'b0;
      m_p0 = '0;   m_p1 = '0;
      m_dual = '0; m_split = '0; m_flush = '0;
   endtask

   task automatic model_edge();
      logic acc, hz;
      acc = model_ready() && (bus.is_i_valid0 || bus.is_i_valid1);
      hz  = model_hazard();
      cyc++;
      m_fl = 1'b0;
      if (bus.is_i_change_pc) begin
         m_i0 = 1'b0; m_i1 = 1'b0; m_fl = 1'b1;
         split_due  = 1'b0;
         ready_from = cyc + FC;
         m_flush++;
      end else if (split_due) begin
         m_i0 = 1'b0; m_i1 = 1'b1; m_p1 = held;
         split_due = 1'b0;
      end else if (acc && hz) begin
         m_i0 = 1'b1; m_i1 = 1'b0; m_p0 = bus.is_i_payload0;
         held = bus.is_i_payload1;
         split_due = 1'b1;
         m_split++;
      end else if (acc) begin
         m_i0 = bus.is_i_valid0; m_i1 = bus.is_i_valid1;
         m_p0 = bus.is_i_payload0; m_p1 = bus.is_i_payload1;
         if (bus.is_i_valid0 && bus.is_i_valid1) m_dual++;
      end else begin
         m_i0 = 1'b0; m_i1 = 1'b0;
      end
   endtask

   task automatic compare_regs();
      logic [31:0] e_dual, e_split, e_flush;
`ifdef ISSUE_SCHED_STATS_EN
      e_dual = m_dual; e_split = m_split; e_flush = m_flush;
`else
      e_dual = 32'd0; e_split = 32'd0; e_flush = 32'd0;
`endif
      check("issue0",    64'(bus.is_o_issue0),    64'(m_i0));
      check("issue1",    64'(bus.is_o_issue1),    64'(m_i1));
      check("flush",     64'(bus.is_o_flush),     64'(m_fl));
      check("payload0",  bus.is_o_payload0,       m_p0);
      check("payload1",  bus.is_o_payload1,       m_p1);
      check("dual_cnt",  64'(bus.is_o_dual_cnt),  64'(e_dual));
      check("split_cnt", 64'(bus.is_o_split_cnt), 64'(e_split));
      check("flush_cnt", 64'(bus.is_o_flush_cnt), 64'(e_flush));
   endtask

   task automatic put(input logic v0, input logic v1, input logic wr0, input logic j0,
                      input logic [4:0] rd0, input logic [4:0] rs1, input logic [4:0] rt1,
                      input logic [63:0] p0, input logic [63:0] p1);
      @(negedge clk); #1;
      bus.is_i_valid0 = v0;   bus.is_i_valid1 = v1;
      bus.is_i_wr0    = wr0;  bus.is_i_jump0  = j0;
      bus.is_i_rd0    = rd0;  bus.is_i_rs1    = rs1; bus.is_i_rt1 = rt1;
      bus.is_i_rs0    = 5'd1; bus.is_i_rt0    = 5'd2; bus.is_i_rd1 = 5'd9;
      bus.is_i_payload0 = p0; bus.is_i_payload1 = p1;
      bus.is_i_change_pc = 1'b0;
   endtask

   task automatic idle(input logic chg);
      @(negedge clk); #1;
      bus.is_i_valid0 = 1'b0; bus.is_i_valid1 = 1'b0;
      bus.is_i_change_pc = chg;
   endtask

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic check_stat(input string name, input logic [31:0] act, input logic [31:0] on_val);
`ifdef ISSUE_SCHED_STATS_EN
      check(name, 64'(act), 64'(on_val));
`else
      check(name, 64'(act), 64'd0);
`endif
   endtask

   initial begin
      bus.is_i_valid0 = 1'b0; bus.is_i_valid1 = 1'b0;
      bus.is_i_rs0 = '0; bus.is_i_rt0 = '0; bus.is_i_rd0 = '0;
      bus.is_i_rs1 = '0; bus.is_i_rt1 = '0; bus.is_i_rd1 = '0;
      bus.is_i_wr0 = 1'b0; bus.is_i_jump0 = 1'b0;
      bus.is_i_payload0 = '0; bus.is_i_payload1 = '0;
      bus.is_i_change_pc = 1'b0;

      fork
         forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else begin
               model_edge();
               #1;
               if (!rst) compare_regs();
            end
         end
         forever begin
            @(negedge clk); #3;
            check("ready", 64'(bus.is_o_ready), 64'(model_ready()));
         end
      join_none

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      check("rst_issue0", 64'(bus.is_o_issue0), 64'd0);
      check("rst_flush", 64'(bus.is_o_flush), 64'd0);
      check("rst_payload1", bus.is_o_payload1, 64'd0);
      check("rst_ready", 64'(bus.is_o_ready), 64'd1);
      rst = 1'b0;

      // Independent pair
      put(1, 1, 1, 0, 5'd3, 5'd4, 5'd5, 64'hA0A0, 64'hA1A1);
      #1 check("indep_ready", 64'(bus.is_o_ready), 64'd1);
      step();
      check("indep_issue0", 64'(bus.is_o_issue0), 64'd1);
      check("indep_issue1", 64'(bus.is_o_issue1), 64'd1);
      check("indep_pay0", bus.is_o_payload0, 64'hA0A0);
      check("indep_pay1", bus.is_o_payload1, 64'hA1A1);
      check_stat("indep_dual_cnt", bus.is_o_dual_cnt, 32'd1);

      // RAW pair through rt1
      put(1, 1, 1, 0, 5'd7, 5'd1, 5'd7, 64'hB0B0, 64'hB1B1);
      step();
      check("raw_issue0", 64'(bus.is_o_issue0), 64'd1);
      check("raw_issue1_c1", 64'(bus.is_o_issue1), 64'd0);
      idle(1'b0);
      #1 check("raw_ready_split", 64'(bus.is_o_ready), 64'd0);
      step();
      check("raw_issue0_c2", 64'(bus.is_o_issue0), 64'd0);
      check("raw_issue1_c2", 64'(bus.is_o_issue1), 64'd1);
      check("raw_pay1", bus.is_o_payload1, 64'hB1B1);
      check_stat("raw_split_cnt", bus.is_o_split_cnt, 32'd1);

      // Write to $0 never splits
      put(1, 1, 1, 0, 5'd0, 5'd0, 5'd3, 64'hC0C0, 64'hC1C1);
      step();
      check("zero_issue1", 64'(bus.is_o_issue1), 64'd1);
      check_stat("zero_split_cnt", bus.is_o_split_cnt, 32'd1);

      // Taken jump cancels the held slot 1
      put(1, 1, 0, 1, 5'd5, 5'd1, 5'd2, 64'hD0D0, 64'hD1D1);
      step();
      check("jmp_issue0", 64'(bus.is_o_issue0), 64'd1);
      idle(1'b1);
      #1 check("jmp_ready_chg", 64'(bus.is_o_ready), 64'd0);
      step();
      check("jmp_flush", 64'(bus.is_o_flush), 64'd1);
      check("jmp_issue1_c2", 64'(bus.is_o_issue1), 64'd0);
      idle(1'b0);
      #1 check("jmp_ready_redir", 64'(bus.is_o_ready), 64'd0);
      step();
      check("jmp_flush_off", 64'(bus.is_o_flush), 64'd0);
      check("jmp_issue1_c3", 64'(bus.is_o_issue1), 64'd0);
      check_stat("jmp_flush_cnt", bus.is_o_flush_cnt, 32'd1);
      @(negedge clk); #2;
      check("jmp_ready_back", 64'(bus.is_o_ready), 64'd1);

      // Not-taken jr: slot 1 issues second cycle
      put(1, 1, 0, 1, 5'd5, 5'd1, 5'd2, 64'hE0E0, 64'hE1E1);
      step();
      idle(1'b0);
      step();
      check("nt_issue1", 64'(bus.is_o_issue1), 64'd1);
      check("nt_pay1", bus.is_o_payload1, 64'hE1E1);
      check("nt_flush", 64'(bus.is_o_flush), 64'd0);

      // Lone slot 1, and wr0 clear with matching regs
      put(0, 1, 1, 0, 5'd6, 5'd6, 5'd6, 64'hF0F0, 64'hF1F1);
      step();
      check("lone1_issue0", 64'(bus.is_o_issue0), 64'd0);
      check("lone1_issue1", 64'(bus.is_o_issue1), 64'd1);
      put(1, 1, 0, 0, 5'd6, 5'd6, 5'd6, 64'h1234, 64'h5678);
      step();
      check("nowr_issue1", 64'(bus.is_o_issue1), 64'd1);
      put(1, 1, 1, 0, 5'd12, 5'd12, 5'd3, 64'h2222, 64'h3333);
      step();
      check("rs_raw_issue1", 64'(bus.is_o_issue1), 64'd0);
      idle(1'b0);
      step();

      // change_pc held two cycles re-pulses flush
      idle(1'b1);
      step();
      check("rep_flush1", 64'(bus.is_o_flush), 64'd1);
      step();
      check("rep_flush2", 64'(bus.is_o_flush), 64'd1);
      idle(1'b0);
      #1 check("rep_ready_redir", 64'(bus.is_o_ready), 64'd0);
      step();
      check_stat("rep_flush_cnt", bus.is_o_flush_cnt, 32'd3);

      // Async reset in the middle of a split
      put(1, 1, 1, 0, 5'd8, 5'd8, 5'd0, 64'h7070, 64'h7171);
      step();
      check("rs_split_issue0", 64'(bus.is_o_issue0), 64'd1);
      @(negedge clk); #1;
      bus.is_i_valid0 = 1'b0; bus.is_i_valid1 = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("rs_issue0", 64'(bus.is_o_issue0), 64'd0);
      check("rs_pay0", bus.is_o_payload0, 64'd0);
      check("rs_flush", 64'(bus.is_o_flush), 64'd0);
      check("rs_dual_cnt", 64'(bus.is_o_dual_cnt), 64'd0);
      @(negedge clk); #1;
      rst = 1'b0;
      #1 check("rs_ready", 64'(bus.is_o_ready), 64'd1);
      step();
      check("rs_held_lost", 64'(bus.is_o_issue1), 64'd0);

      repeat (3) idle(1'b0);
      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
